pmem_arbiter: RTL
=================

# pmem_arbiter

Two-port arbiter that shares one pmem-style memory port (rd/wr/len/addr/write_data with accept/ack/error/read_data) between two requesters, e.g. the uncached path and the cache core ahead of the AXI bridge, or instruction and data caches ahead of a single AXI master. It replaces static select-driven muxing with hardware arbitration: it picks a winner, locks the grant for the whole burst, counts beats and responses, routes each ack back to the owner only, and releases the port after the final response.

## Interface
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- inportN_rd_i  in  1  read request (N = 0, 1).
- inportN_wr_i  in  4  write byte strobes; non-zero means a write beat.
- inportN_len_i  in  8  burst length minus one; sampled on the first accepted beat.
- inportN_addr_i  in  32  request address.
- inportN_write_data_i  in  32  write beat data.
- inportN_accept_o  out  1  beat accepted.
- inportN_ack_o  out  1  response beat for port N.
- inportN_error_o  out  1  error, valid with inportN_ack_o.
- inportN_read_data_o  out  32  read data, valid with ack.
- outport_rd_o, outport_wr_o[3:0], outport_len_o[7:0], outport_addr_o[31:0], outport_write_data_o[31:0]  out  request forwarded from the granted port.
- outport_accept_i, outport_ack_i, outport_error_i  in  1  downstream handshake.
- outport_read_data_i  in  32  downstream read data.
- grant_o  out  1  current or pending owner (0/1).
- busy_o  out  1  transaction in flight (state != IDLE).

## Operation
- Protocol: a read is one accepted command followed by len+1 ack beats. A write is len+1 accepted beats (len is taken from the first beat) followed by exactly one ack. Requesters hold rd/wr/addr/data stable until accepted and never withdraw a request.
- Only one transaction is outstanding at a time.
- States:
  - IDLE: no owner.
  - WR_BEATS: further write beats remain.
  - WAIT_RESP: acks outstanding.
- IDLE:
  - The winner is the only requesting port, or, when both request, the port not served last (FAIR=1) or port 0 (FAIR=0).
  - The winner's request is driven to the outport combinationally. Its accept_o mirrors outport_accept_i; the loser sees accept_o=0 and the outport sees none of its signals.
  - On an accepted read: owner := winner, ack_cnt := len, go to WAIT_RESP.
  - On an accepted write with len=0: ack_cnt := 0, go to WAIT_RESP.
  - On an accepted write with len>0: beat_cnt := len-1, go to WR_BEATS.
- WR_BEATS: only the owner is forwarded. Each accepted beat decrements beat_cnt; the beat accepted when beat_cnt==0 moves to WAIT_RESP with ack_cnt := 0.
- WAIT_RESP: outport rd/wr held 0. Each outport_ack_i is routed to the owner's ack_o/error_o and decrements ack_cnt. The ack seen when ack_cnt==0 returns to IDLE and sets last_grant := owner.
- Error: forwarded with its ack. It does not shorten the burst; all len+1 read acks are still expected.
- Acks in IDLE or WR_BEATS are spurious: they are dropped and no inport ack is raised.
- read_data is broadcast to both ports. Only ack_o qualifies it.

## Timing
- Reset (rst_ni=0 at an edge):
  - state := IDLE, owner := 0, last_grant := 1 (so port 0 wins the first tie), counters := 0.
  - Every output is 0 except pass-through combinational paths. With no requests asserted, all outputs are 0.
- Reset in the middle of a transaction aborts it immediately. Downstream acks arriving afterwards are dropped as spurious.
- Request to outport: 0 cycles (combinational) in IDLE and WR_BEATS.
- Ack to inport: 0 cycles (combinational routing from registered owner).
- After the final ack, the next transaction can be accepted from the following cycle. This gives a 1-cycle minimum gap.
- ack_cnt and beat_cnt are 8 bits; len=255 yields 256 beats/acks with no wrap error.
- Simultaneous events:
  - A new request arriving during the final-ack cycle waits in IDLE for the next cycle.
  - Both ports requesting in IDLE are resolved by the rule above in that same cycle.
  - grant_o changes only in IDLE.

## Structure
- Package pmem_arb_pkg holds:
  - the state encoding (IDLE=2'd0, WR_BEATS=2'd1, WAIT_RESP=2'd2);
  - the width constants (LEN_W=8, ADDR_W=32, DATA_W=32, STRB_W=4).
- Sub-module pmem_arb_rr is the 2-way winner picker (inputs: req[1:0], last_grant, FAIR; output: winner). It is purely combinational.
- The FSM, counters and routing live in pmem_arbiter.

## Test plan
- Port 0 reads len=3 at 0x1000 with downstream accept immediate and 4 acks with data 0xA0..0xA3 -> inport0 sees 4 acks with matching data; inport1 sees no ack; busy_o drops the cycle after the 4th ack.
- Both ports request in the same IDLE cycle with FAIR=1 after reset -> port 0 granted first; next tie -> port 1. With FAIR=0 -> port 0 wins both.
- Port 1 writes len=2 while port 0 requests a read, with accept stalled 2 cycles on beat 2 -> all three port-1 beats are forwarded contiguously without port-0 interleave, one ack goes to port 1, then port 0 is granted.
- A read of len=1 gets an error on the first ack -> inport ack with error_o=1, then the second ack is still routed; the transaction ends only after 2 acks.
- A spurious outport_ack_i in IDLE -> no inport ack, and state stays IDLE.
- rst_ni pulsed low during WAIT_RESP of a len=7 read, followed by 3 late acks -> state IDLE, no inport acks, and a fresh request is granted normally.

Source files
------------

// File: rtl/pmem_arb_pkg.sv
// Shared encodings and widths for the two-port pmem arbiter.
package pmem_arb_pkg;

    localparam int LEN_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WR_BEATS  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pmem_arb_if.sv
// pmem-style request/response port: master issues rd/wr beats, slave accepts and acks.
interface pmem_arb_if;
    import pmem_arb_pkg::*;

    // A beat transfers in a cycle where (rd || wr != 0) && accept; the request is held
    // stable until then and never withdrawn. ack is a one-cycle response beat that
    // qualifies error and read_data; it has no back-pressure.
    logic              rd;
    logic [STRB_W-1:0] wr;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              accept;
    logic              ack;
    logic              error;
    logic [DATA_W-1:0] read_data;

    modport master (
        output rd, wr, len, addr, write_data,
        input  accept, ack, error, read_data
    );

    modport slave (
        input  rd, wr, len, addr, write_data,
        output accept, ack, error, read_data
    );

endinterface

// File: rtl/pmem_arb_rr.sv
// Two-way winner picker: round-robin on ties when FAIR, otherwise port 0 always wins ties.
module pmem_arb_rr #(
    parameter logic FAIR = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end else if (req == 2'b11) begin
            winner = FAIR ? ~last_grant : 1'b0;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one pmem port between two requesters, locking the grant for a whole burst
// and routing each response beat back to the owning port only.
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter logic FAIR = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    pmem_arb_if.slave   inport0,
    pmem_arb_if.slave   inport1,
    pmem_arb_if.master  outport,
    output logic        grant_o,
    output logic        busy_o,
    output arb_state_t  state_o
);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] ack_cnt_q, ack_cnt_d;

    logic              req0, req1, winner, sel;
    logic              sel_rd, sel_req;
    logic [STRB_W-1:0] sel_wr;
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              fwd, fire, ack_live;

    assign req0 = inport0.rd | (|inport0.wr);
    assign req1 = inport1.rd | (|inport1.wr);

    pmem_arb_rr #(.FAIR(FAIR)) u_rr (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    // The arbitration result is only live in IDLE; afterwards the registered owner rules.
    assign sel       = (state_q == IDLE) ? winner : owner_q;
    assign sel_rd    = sel ? inport1.rd         : inport0.rd;
    assign sel_wr    = sel ? inport1.wr         : inport0.wr;
    assign sel_len   = sel ? inport1.len        : inport0.len;
    assign sel_addr  = sel ? inport1.addr       : inport0.addr;
    assign sel_wdata = sel ? inport1.write_data : inport0.write_data;
    assign sel_req   = sel_rd | (|sel_wr);

    assign fwd  = (state_q != WAIT_RESP) && sel_req;
    assign fire = fwd && outport.accept;

    assign outport.rd         = fwd & sel_rd;
    assign outport.wr         = fwd ? sel_wr    : '0;
    assign outport.len        = fwd ? sel_len   : '0;
    assign outport.addr       = fwd ? sel_addr  : '0;
    assign outport.write_data = fwd ? sel_wdata : '0;

    assign inport0.accept = fire & ~sel;
    assign inport1.accept = fire &  sel;

    // Acks outside WAIT_RESP are spurious (including those left over from an aborted burst).
    assign ack_live       = (state_q == WAIT_RESP) && outport.ack;
    assign inport0.ack    = ack_live & ~owner_q;
    assign inport1.ack    = ack_live &  owner_q;
    assign inport0.error  = ack_live & ~owner_q & outport.error;
    assign inport1.error  = ack_live &  owner_q & outport.error;
    assign inport0.read_data = outport.read_data;
    assign inport1.read_data = outport.read_data;

    assign grant_o = sel;
    assign busy_o  = (state_q != IDLE);
    assign state_o = state_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    owner_d = winner;
                    if (sel_rd) begin
                        ack_cnt_d = sel_len;
                        state_d   = WAIT_RESP;
                    end else if (sel_len == '0) begin
                        ack_cnt_d = '0;
                        state_d   = WAIT_RESP;
                    end else begin
                        beat_cnt_d = sel_len - 1'b1;
                        state_d    = WR_BEATS;
                    end
                end
            end
            WR_BEATS: begin
                if (fire) begin
                    if (beat_cnt_q == '0) begin
                        ack_cnt_d = '0;
                        state_d   = WAIT_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                if (outport.ack) begin
                    if (ack_cnt_q == '0) begin
                        last_grant_d = owner_q;
                        state_d      = IDLE;
                    end else begin
                        ack_cnt_d = ack_cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            ack_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
        end
    end

endmodule
